// File: rtl/tx_resp_buffer.sv
// Response byte FIFO between the controller's TX byte strobe and the UART TX synchroniser.
// Bytes leave one at a time: a level request is held until the transmitter's busy rises.
module tx_resp_buffer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_BITS  = 3,
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_valid,
  input  logic                busy_sync,
  output logic [WIDTH-1:0]    tx_data,
  output logic                tx_valid,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] count,
  output logic                overflow,
  output logic                ack_err
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int TMAX  = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t                state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_BITS:0]   count_reg;
  logic [WIDTH-1:0]      tx_data_reg;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  overflow_reg, ack_err_reg;
  logic                  launch, pop, timeout, wr_accept, wr_drop;

  assign full      = (count_reg == DEPTH_CNT);
  assign empty     = (count_reg == '0);
  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  assign wr_accept = wr_valid && (!full || pop);
  assign wr_drop   = wr_valid && full && !pop;

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign ack_err  = ack_err_reg;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    tx_valid_next = tx_valid_reg;
    launch        = 1'b0;
    pop           = 1'b0;
    timeout       = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_valid_next = 1'b0;
        if (!empty && !busy_sync) begin
          state_next    = SEND;
          launch        = 1'b1;
          tx_valid_next = 1'b1;
          timer_next    = '0;
        end
      end
      SEND: begin
        if (busy_sync) begin
          pop           = 1'b1;
          tx_valid_next = 1'b0;
          state_next    = WAIT_DONE;
        end else if (timer_reg == ACK_LAST) begin
          // Give up on this attempt; the head stays in place and is relaunched.
          timeout       = 1'b1;
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy_sync) begin
          timer_next = '0;
          state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (timer_reg == GAP_LAST) state_next = IDLE;
        else                       timer_next = timer_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      overflow_reg <= 1'b0;
      ack_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      tx_valid_reg <= tx_valid_next;
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)       rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (DEPTH_BITS+1)'(wr_accept) - (DEPTH_BITS+1)'(pop);
      if (launch)  tx_data_reg  <= mem[rd_ptr_reg];
      if (wr_drop) overflow_reg <= 1'b1;
      if (timeout) ack_err_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_reg] <= wr_data;
  end

endmodule
